tn_serv_timer: RTL and testbench
================================

// Module: tn_serv_timer
// PURPOSE
//  RISC-V machine timer (mtime/mtimecmp) as a Wishbone-classic slave on the SERV dbus.
//  - Consumes dbus cycles decoded to its window.
//  - Drives the core's i_timer_irq, replacing today's tie-off to 0.
//  - Feeds o_wb_rdt/o_wb_ack into the top-level dbus read mux.
// PARAMETERS
//  PRESCALE_W  16            width of PRESCALE register and tick divider
//  CMP_RST     64'hFFFF_FFFF_FFFF_FFFF  reset value of mtimecmp (no IRQ out of reset)
// PORTS
//  clk          in   1   system clock, single clock domain
//  i_rst        in   1   asynchronous, active-high reset
//  i_wb_adr     in   3   word index within window (dbus adr[4:2])
//  i_wb_dat     in   32  write data
//  i_wb_sel     in   4   byte-lane enables for writes
//  i_wb_we      in   1   1 = write, 0 = read
//  i_wb_cyc     in   1   cycle request, already qualified by window decode
//  o_wb_rdt     out  32  read data, registered
//  o_wb_ack     out  1   one-cycle acknowledge
//  o_timer_irq  out  1   level timer interrupt to serv_top i_timer_irq
// BEHAVIOUR
//  Reset (async assert, sync release) values:
//   - o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0
//   - mtime=0, mtimecmp=CMP_RST, CTRL=0, PRESCALE=0, divider=0
//  Register map (word index):
//   0 MTIME_LO   1 MTIME_HI   2 MTIMECMP_LO   3 MTIMECMP_HI
//   4 CTRL (bit0 EN, bit1 IE, others RAZ/WI)   5 PRESCALE (PRESCALE_W bits, upper RAZ)
//   6,7 unmapped: read 0, writes ignored, still acked
//  Handshake:
//   - o_wb_ack <= i_wb_cyc && !o_wb_ack, so ack is 1 cycle after cyc and never back-to-back.
//   - The access is committed on the edge that sets ack.
//     Writes are byte-masked by i_wb_sel; o_wb_rdt is loaded on that same edge.
//   - o_wb_rdt holds its value otherwise.
//   - cyc dropped before ack: no side effect.
//  Tick:
//   - When EN=1 the divider counts 0..PRESCALE; at PRESCALE it emits tick and wraps to 0.
//   - PRESCALE=0 gives a tick every cycle. EN=0 holds the divider at 0.
//   - A PRESCALE write resets the divider to 0.
//  mtime:
//   - 64-bit, +1 per tick, carry LO->HI in the same cycle.
//   - Wraps 2^64-1 -> 0 silently.
//  Write vs tick in the same cycle:
//   - A bus write to MTIME_LO/HI wins for the written bytes that cycle; the tick is dropped.
//   - Unwritten bytes keep the old value, with no increment applied.
//  IRQ:
//   - o_timer_irq <= IE && (mtime >= mtimecmp), unsigned 64-bit compare.
//   - Registered, 1 cycle after the condition holds. Level, not pulse.
//   - Cleared only by raising mtimecmp, lowering mtime, or clearing IE.
//  Reads:
//   - Reading HI returns the live HI. Software uses the HI-LO-HI retry; there is no snapshot latch.
//  Reset mid-transaction: ack and any pending access are discarded, and all state returns to reset values.
// STRUCTURE
//  Package tn_serv_timer_pkg:
//   - word-index constants (MTIME_LO..PRESCALE)
//   - CTRL bit positions (CTRL_EN=0, CTRL_IE=1)
//   - typedef ctrl_t
//  Sub-module tn_timer_prescaler: divider plus tick output, with inputs en, prescale, restart.
//  Top-level integration:
//   - dbus window at adr[8]=0 && adr[7]=1
//   - ack/rdt OR-ed with the GPIO slave into i_dbus_ack/i_dbus_rdt
// TESTING
//  1. Reset, read all 8 words -> LO/HI/CTRL/PRESCALE read 0, CMP words read FFFF_FFFF; acks 1 cycle after cyc; irq=0.
//  2. PRESCALE=3, CTRL=1, wait 40 clk -> MTIME_LO=10 (+/-1 for write latency); EN=0 then freezes the value.
//  3. MTIME_LO=FFFF_FFFF, HI=0, PRESCALE=0, EN=1 -> next tick gives HI=1, LO=0; carry is same-cycle.
//  4. CMP=0x20, CTRL=3 -> irq rises 1 cycle after mtime reaches 0x20; writing CMP_LO=FFFF_FFFF drops irq next cycle.
//  5. Write MTIME_LO sel=4'b0001 data=0xAA on a tick cycle -> byte0=0xAA, bytes1-3 unchanged, no increment.
//  6. Assert i_rst while cyc is high, ack pending, and irq=1 -> ack, irq, and all registers reset immediately.

Source files
------------

// File: rtl/tn_serv_timer_pkg.sv
// Shared definitions for the SERV machine timer: register word indices,
// CTRL bit positions and the byte-lane merge helper used for bus writes.
package tn_serv_timer_pkg;

    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CTRL        = 3'd4;
    localparam logic [2:0] PRESCALE    = 3'd5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef struct packed {
        logic ie;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tn_timer_prescaler.sv
// Tick divider: counts 0..prescale while enabled and emits a one-cycle tick
// on the terminal count. Disabled or restarted, it sits at zero.
module tn_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  restart,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_r;

    assign tick = en && (div_r == prescale);

    // Divider count, wrapping on tick.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else if (restart || !en || tick) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else begin
            div_r <= div_r + PRESCALE_W'(1'b1);
        end
    end

endmodule

// File: rtl/tn_serv_timer.sv
// RISC-V mtime/mtimecmp timer as a Wishbone-classic slave on the SERV dbus,
// producing the level machine-timer interrupt.
module tn_serv_timer
    import tn_serv_timer_pkg::*;
#(
    parameter int          PRESCALE_W = 16,
    parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    logic                  ack_r;
    logic [31:0]           rdt_r;
    logic                  irq_r;
    logic [63:0]           mtime_r;
    logic [63:0]           mtimecmp_r;
    ctrl_t                 ctrl_r;
    logic [PRESCALE_W-1:0] prescale_r;

    logic                  access_s;
    logic                  wr_s;
    logic                  tick_s;
    logic [31:0]           rd_data_s;
    logic [31:0]           wr_merged_s;
    logic [63:0]           mtime_nxt_s;

    assign access_s    = i_wb_cyc && !ack_r;
    assign wr_s        = access_s && i_wb_we;
    // Merging against the addressed register's read view keeps RAZ bits at zero.
    assign wr_merged_s = byte_merge(rd_data_s, i_wb_dat, i_wb_sel);

    assign o_wb_ack    = ack_r;
    assign o_wb_rdt    = rdt_r;
    assign o_timer_irq = irq_r;

    tn_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .i_rst    (i_rst),
        .en       (ctrl_r.en),
        .prescale (prescale_r),
        .restart  (wr_s && (i_wb_adr == PRESCALE)),
        .tick     (tick_s)
    );

    // Read view of the register window.
    always_comb begin
        rd_data_s = 32'd0;
        case (i_wb_adr)
            MTIME_LO:    rd_data_s = mtime_r[31:0];
            MTIME_HI:    rd_data_s = mtime_r[63:32];
            MTIMECMP_LO: rd_data_s = mtimecmp_r[31:0];
            MTIMECMP_HI: rd_data_s = mtimecmp_r[63:32];
            CTRL:        rd_data_s = {30'd0, ctrl_r};
            PRESCALE:    rd_data_s = 32'(prescale_r);
            default:     rd_data_s = 32'd0;
        endcase
    end

    // Next mtime: a bus write to either half suppresses that cycle's tick.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_s && (i_wb_adr == MTIME_LO)) begin
            mtime_nxt_s[31:0] = wr_merged_s;
        end else if (wr_s && (i_wb_adr == MTIME_HI)) begin
            mtime_nxt_s[63:32] = wr_merged_s;
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Bus handshake and registered read data.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ack_r <= 1'b0;
            rdt_r <= 32'd0;
        end else begin
            ack_r <= access_s;
            if (access_s) begin
                rdt_r <= rd_data_s;
            end
        end
    end

    // Configuration registers written from the bus.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mtimecmp_r <= CMP_RST;
            ctrl_r     <= '{ie: 1'b0, en: 1'b0};
            prescale_r <= {PRESCALE_W{1'b0}};
        end else if (wr_s) begin
            case (i_wb_adr)
                MTIMECMP_LO: mtimecmp_r[31:0]  <= wr_merged_s;
                MTIMECMP_HI: mtimecmp_r[63:32] <= wr_merged_s;
                CTRL:        ctrl_r            <= ctrl_t'(wr_merged_s[1:0]);
                PRESCALE:    prescale_r        <= wr_merged_s[PRESCALE_W-1:0];
                default:     ctrl_r            <= ctrl_r;
            endcase
        end
    end

    // Free-running time base.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            mtime_r <= 64'd0;
        end else begin
            mtime_r <= mtime_nxt_s;
        end
    end

    // Level interrupt, compared on the current register values.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ctrl_r.ie && (mtime_r >= mtimecmp_r);
        end
    end

endmodule

// File: tb/tb_tn_serv_timer.sv
// Directed plus randomized bench for tn_serv_timer with a cycle-level
// reference model of the timer's register behaviour.
module tb_tn_serv_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic        m_ack;
    logic [31:0] m_rdt;
    logic        m_irq;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_ie;
    logic [15:0] m_pre;
    int unsigned m_div;

    always #5 clk = ~clk;

    tn_serv_timer dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_cyc    (cyc),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_timer_irq (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ie, m_en};
            3'd5: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ack = 1'b0; m_rdt = 32'd0; m_irq = 1'b0;
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en = 1'b0; m_ie = 1'b0; m_pre = 16'd0; m_div = 0;
    endtask

    // one clock: predict from the current inputs, clock, then compare
    task automatic step();
        logic acc, wr, tick;
        logic n_ack, n_irq, n_en, n_ie;
        logic [31:0] n_rdt, w;
        logic [63:0] n_mtime, n_cmp;
        logic [15:0] n_pre;
        int unsigned n_div;
        acc   = cyc && !m_ack;
        wr    = acc && we;
        tick  = m_en && (m_div == int'(m_pre));
        n_ack = acc;
        n_rdt = acc ? model_read(adr) : m_rdt;
        n_irq = m_ie && (m_mtime >= m_cmp);
        w     = merge(model_read(adr), dat, sel);
        n_mtime = m_mtime; n_cmp = m_cmp; n_en = m_en; n_ie = m_ie; n_pre = m_pre;
        if (wr && adr == 3'd0)      n_mtime[31:0]  = w;
        else if (wr && adr == 3'd1) n_mtime[63:32] = w;
        else if (tick)              n_mtime = m_mtime + 64'd1;
        if (wr && adr == 3'd2) n_cmp[31:0]  = w;
        if (wr && adr == 3'd3) n_cmp[63:32] = w;
        if (wr && adr == 3'd4) begin n_en = w[0]; n_ie = w[1]; end
        if (wr && adr == 3'd5) n_pre = w[15:0];
        if ((wr && adr == 3'd5) || !m_en || tick) n_div = 0;
        else n_div = m_div + 1;
        @(posedge clk);
        #1;
        m_ack = n_ack; m_rdt = n_rdt; m_irq = n_irq; m_mtime = n_mtime;
        m_cmp = n_cmp; m_en = n_en; m_ie = n_ie; m_pre = n_pre; m_div = n_div;
        check("ack", ack, m_ack);
        check("rdt", rdt, m_rdt);
        check("irq", irq, m_irq);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; dat = d; sel = s; we = 1'b1; cyc = 1'b1;
        step();
        check("wr_ack_one_cycle", ack, 1'b1);
        cyc = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        adr = a; sel = 4'h0; we = 1'b0; cyc = 1'b1;
        step();
        check("rd_ack_one_cycle", ack, 1'b1);
        d = rdt;
        cyc = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] v, exp5;
        logic [2:0]  ra;
        logic        rose;

        rst = 1'b1; adr = 3'd0; dat = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", ack, 1'b0);
        check("reset_rdt", rdt, 32'd0);
        check("reset_irq", irq, 1'b0);
        rst = 1'b0;

        // reset values of all eight words
        for (int i = 0; i < 8; i++) begin
            wb_read(3'(i), v);
            check($sformatf("reset_word%0d", i), v, (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'd0);
        end

        // prescaled counting and freeze
        wb_write(3'd4, 32'd0, 4'hF);
        wb_write(3'd0, 32'd0, 4'hF);
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd5, 32'd3, 4'hF);
        wb_write(3'd4, 32'd1, 4'hF);
        repeat (40) step();
        wb_read(3'd0, v);
        check("prescale3_lo_near_10", (v >= 32'd9 && v <= 32'd11), 1'b1);
        wb_write(3'd4, 32'd0, 4'hF);
        repeat (10) step();
        wb_read(3'd0, v);
        check("frozen_lo", v, m_mtime[31:0]);
        check("frozen_lo_range", (v >= 32'd9 && v <= 32'd12), 1'b1);

        // same-cycle carry into HI
        wb_write(3'd5, 32'd0, 4'hF);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd4, 32'd1, 4'hF);
        wb_read(3'd1, v);
        check("carry_hi", v, 32'd1);
        wb_read(3'd0, v);
        check("carry_lo_small", (v < 32'd8), 1'b1);

        // interrupt rise and clear by raising mtimecmp
        wb_write(3'd4, 32'd0, 4'hF);
        wb_write(3'd0, 32'd0, 4'hF);
        wb_write(3'd1, 32'd0, 4'hF);
        wb_write(3'd3, 32'd0, 4'hF);
        wb_write(3'd2, 32'h20, 4'hF);
        wb_write(3'd4, 32'd3, 4'hF);
        rose = 1'b0;
        for (int i = 0; i < 100 && !rose; i++) begin
            step();
            rose = irq;
        end
        check("irq_rose", rose, 1'b1);
        adr = 3'd2; dat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; cyc = 1'b1;
        step();
        check("irq_held_on_cmp_write", irq, 1'b1);
        cyc = 1'b0; we = 1'b0;
        step();
        check("irq_dropped", irq, 1'b0);

        // partial byte write on a tick cycle
        exp5 = m_mtime[31:0];
        exp5 = {exp5[31:8], 8'hAA} + 32'd2;
        wb_write(3'd0, 32'h0000_00AA, 4'b0001);
        wb_write(3'd4, 32'd0, 4'hF);
        wb_read(3'd0, v);
        check("byte0_write_wins_tick", v, exp5);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                step();
            end else begin
                ra = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) begin
                    wb_read(ra, v);
                end else begin
                    case (ra)
                        3'd1, 3'd3: v = 32'($urandom_range(0, 1));
                        3'd5:       v = 32'($urandom_range(0, 3));
                        3'd2:       v = 32'($urandom_range(0, 400));
                        default:    v = $urandom;
                    endcase
                    wb_write(ra, v, 4'($urandom_range(0, 15)));
                end
            end
        end

        // reset in the middle of a pending access with irq asserted
        wb_write(3'd3, 32'd0, 4'hF);
        wb_write(3'd2, 32'd0, 4'hF);
        wb_write(3'd4, 32'd2, 4'hF);
        step();
        check("pre_reset_irq", irq, 1'b1);
        adr = 3'd0; we = 1'b0; cyc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_ack", ack, 1'b0);
        check("async_reset_irq", irq, 1'b0);
        check("async_reset_rdt", rdt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held_ack", ack, 1'b0);
        cyc = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_read(3'(i), v);
            check($sformatf("post_reset_word%0d", i), v, (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
